// File: rtl/axi_lite_master_pkg.sv
// ============================================================================
// axi_lite_pkg : shared types and default widths for the AXI-lite master
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W_DEF  = 32;
  localparam int unsigned AXI_DATA_W_DEF  = 32;
  localparam int unsigned AXI_TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } mst_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_lite_master_if.sv
// ============================================================================
// axi_lite_master_if : command/response port plus AXI-lite channels
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axi_lite_master_if
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W_DEF,
  parameter int unsigned DATA_W = AXI_DATA_W_DEF
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_write;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   aw_addr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          b_resp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   ar_addr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;

  // Bridge-side view: sink on the command port, master on the AXI channels
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready, wready, bvalid, b_resp, arready, rvalid, r_data, r_resp,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           awvalid, aw_addr, wvalid, w_data, w_strb, bready,
           arvalid, ar_addr, rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready, wready, bvalid, b_resp, arready, rvalid, r_data, r_resp,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           awvalid, aw_addr, wvalid, w_data, w_strb, bready,
           arvalid, ar_addr, rready
  );

endinterface

`default_nettype wire

// File: rtl/axi_lite_master_timeout_ctr.sv
// ============================================================================
// axi_lite_timeout_ctr : busy-cycle watchdog, flags the TIMEOUT_CYCLES-th cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_lite_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count holds the number of busy cycles already elapsed before this one
  assign expire_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (run_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_master.sv
// ============================================================================
// axi_lite_master : single-outstanding command-to-AXI-lite bridge
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = AXI_ADDR_W_DEF,
  parameter int unsigned DATA_W         = AXI_DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = AXI_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  axi_lite_master_if.master bus
);

  mst_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                write_q, write_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  axi_resp_e           rsp_resp_q, rsp_resp_d;

  logic cmd_hs;
  logic timeout;

  assign cmd_hs = (state_q == IDLE) && bus.cmd_valid;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic busy;
  assign busy = (state_q != IDLE) && (state_q != RSP);

  axi_lite_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .start_i  (cmd_hs),
    .run_i    (busy),
    .expire_o (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d    = bus.cmd_addr;
          wdata_d   = bus.cmd_wdata;
          wstrb_d   = bus.cmd_wstrb;
          write_d   = bus.cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.cmd_write ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (bus.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.rvalid) begin
          rsp_rdata_d = bus.r_data;
          rsp_resp_d  = axi_resp_e'(bus.r_resp);
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, possibly in the same cycle
        if (bus.awready) aw_done_d = 1'b1;
        if (bus.wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bus.bvalid) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = axi_resp_e'(bus.b_resp);
          rsp_write_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      rsp_rdata_d = '0;
      rsp_resp_d  = SLVERR;
      rsp_write_d = write_q;
      state_d     = RSP;
    end

    arvalid_d   = (state_d == RD_ADDR);
    rready_d    = (state_d == RD_DATA);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.ar_addr   = addr_q;
  assign bus.rready    = rready_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.aw_addr   = addr_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.w_data    = wdata_q;
  assign bus.w_strb    = wstrb_q;
  assign bus.bready    = bready_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ============================================================================
// tb_axi_lite_master : directed bench with a transaction-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_master;

  logic clk;
  logic rst;

  axi_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs, set by the directed sequence
  int          ar_delay = 0;
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          r_delay  = 0;
  int          b_delay  = 0;
  logic [31:0] rd_value = 32'h0;
  logic [1:0]  rd_resp  = 2'd0;
  logic [1:0]  bresp_cfg = 2'd0;
  logic        spurious = 1'b0;
  logic        exp_timeout = 1'b0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } txn_t;

  txn_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
  endtask

  // Slave: each ready/valid rises after its configured wait once the master asks
  initial begin
    int ar_c, aw_c, w_c, r_c, b_c;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    bus.arready = 0; bus.awready = 0; bus.wready = 0; bus.rvalid = 0; bus.bvalid = 0;
    bus.r_data = 0; bus.r_resp = 0; bus.b_resp = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.r_data = rd_value;
      bus.r_resp = rd_resp;
      bus.b_resp = bresp_cfg;
      if (spurious) begin
        bus.arready = 1; bus.awready = 1; bus.wready = 1; bus.rvalid = 1; bus.bvalid = 1;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
      end else begin
        if (bus.arvalid) begin
          if (ar_c >= ar_delay) bus.arready = 1; else begin bus.arready = 0; ar_c++; end
        end else begin bus.arready = 0; ar_c = 0; end
        if (bus.awvalid) begin
          if (aw_c >= aw_delay) bus.awready = 1; else begin bus.awready = 0; aw_c++; end
        end else begin bus.awready = 0; aw_c = 0; end
        if (bus.wvalid) begin
          if (w_c >= w_delay) bus.wready = 1; else begin bus.wready = 0; w_c++; end
        end else begin bus.wready = 0; w_c = 0; end
        if (bus.rready) begin
          if (r_c >= r_delay) bus.rvalid = 1; else begin bus.rvalid = 0; r_c++; end
        end else begin bus.rvalid = 0; r_c = 0; end
        if (bus.bready) begin
          if (b_c >= b_delay) bus.bvalid = 1; else begin bus.bvalid = 0; b_c++; end
        end else begin bus.bvalid = 0; b_c = 0; end
      end
    end
  end

  // Reference model: one outstanding transaction, checked every cycle
  initial begin
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_ara, p_awa, p_wd;
    txn_t cur, nt;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_ara = 0; p_awa = 0; p_wd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        p_arv = 0; p_awv = 0; p_wv = 0;
      end else begin
        chk("model_cmd_ready", bus.cmd_ready, q.size() == 0);
        chk("model_rsp_excl", bus.rsp_valid && (bus.arvalid || bus.awvalid || bus.wvalid
            || bus.rready || bus.bready), 0);
        if (!exp_timeout) begin
          if (p_arv && !p_arr) chk("model_ar_hold", {bus.arvalid, bus.ar_addr}, {1'b1, p_ara});
          if (p_awv && !p_awr) chk("model_aw_hold", {bus.awvalid, bus.aw_addr}, {1'b1, p_awa});
          if (p_wv && !p_wr)   chk("model_w_hold", {bus.wvalid, bus.w_data}, {1'b1, p_wd});
        end
        if (q.size() == 0) begin
          chk("model_idle_quiet", {bus.rsp_valid, bus.arvalid, bus.awvalid, bus.wvalid,
              bus.rready, bus.bready}, 0);
        end else begin
          cur = q[0];
          if (cur.write) begin
            chk("model_no_rd_on_wr", {bus.arvalid, bus.rready}, 0);
            if (bus.awvalid) chk("model_aw_addr", bus.aw_addr, cur.addr);
            if (bus.wvalid)  chk("model_w_data", {bus.w_strb, bus.w_data}, {cur.strb, cur.wdata});
          end else begin
            chk("model_no_wr_on_rd", {bus.awvalid, bus.wvalid, bus.bready}, 0);
            if (bus.arvalid) chk("model_ar_addr", bus.ar_addr, cur.addr);
          end
          if (bus.rsp_valid) begin
            chk("model_rsp", {bus.rsp_write, bus.rsp_resp, bus.rsp_rdata},
                {cur.write, cur.resp, cur.rdata});
            if (bus.rsp_ready) void'(q.pop_front());
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          nt.write = bus.cmd_write;
          nt.addr  = bus.cmd_addr;
          nt.wdata = bus.cmd_wdata;
          nt.strb  = bus.cmd_wstrb;
          nt.rdata = bus.cmd_write ? 32'h0 : rd_value;
          nt.resp  = bus.cmd_write ? bresp_cfg : rd_resp;
          if (exp_timeout) begin
            nt.rdata = 32'h0;
            nt.resp  = 2'd2;
          end
          q.push_back(nt);
        end
        p_arv = bus.arvalid; p_arr = bus.arready; p_ara = bus.ar_addr;
        p_awv = bus.awvalid; p_awr = bus.awready; p_awa = bus.aw_addr;
        p_wv  = bus.wvalid;  p_wr  = bus.wready;  p_wd  = bus.w_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
    bus.cmd_wdata = 0; bus.cmd_wstrb = 0; bus.rsp_ready = 1;
    repeat (3) tick();

    chk("rst_axi_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata}, 0);
    chk("rst_addr_data", {bus.ar_addr, bus.aw_addr, bus.w_data, bus.w_strb}, 0);
    rst = 1'b0;
    tick();
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    // Slave noise while idle must be ignored
    spurious = 1'b1;
    tick(); tick();
    spurious = 1'b0;
    tick();
    chk("spurious_ignored", {bus.cmd_ready, bus.rsp_valid, bus.arvalid, bus.awvalid}, 4'b1000);

    // Zero-wait read
    rd_value = 32'hDEADBEEF; rd_resp = 2'd0;
    drive_cmd(1'b0, 32'hABCDEF10, 32'h0, 4'h0);
    tick(); bus.cmd_valid = 0;
    chk("rd_c1_arvalid", {bus.arvalid, bus.rready, bus.cmd_ready}, 3'b100);
    chk("rd_c1_ar_addr", bus.ar_addr, 32'hABCDEF10);
    tick();
    chk("rd_c2_rready", {bus.arvalid, bus.rready, bus.rsp_valid}, 3'b010);
    tick();
    chk("rd_c3_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata},
        {1'b1, 1'b0, 2'd0, 32'hDEADBEEF});
    tick();
    chk("rd_c4_idle", {bus.rsp_valid, bus.cmd_ready}, 2'b01);

    // Write with W accepted three cycles after AW
    aw_delay = 0; w_delay = 3; bresp_cfg = 2'd0;
    drive_cmd(1'b1, 32'hFFFFFFFF, 32'h12345678, 4'hF);
    tick(); bus.cmd_valid = 0;
    chk("wr_c1_valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b110);
    chk("wr_c1_payload", {bus.aw_addr, bus.w_data, bus.w_strb}, {32'hFFFFFFFF, 32'h12345678, 4'hF});
    tick();
    chk("wr_c2_aw_drop", {bus.awvalid, bus.wvalid}, 2'b01);
    tick();
    chk("wr_c3_w_held", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    tick();
    chk("wr_c4_w_held", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    tick();
    chk("wr_c5_bready", {bus.wvalid, bus.bready, bus.rsp_valid}, 3'b010);
    tick();
    chk("wr_c6_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata},
        {1'b1, 1'b1, 2'd0, 32'h0});
    tick();

    // DECERR write response held under backpressure
    w_delay = 0; bresp_cfg = 2'd3; bus.rsp_ready = 0;
    drive_cmd(1'b1, 32'h00000040, 32'hA5A5A5A5, 4'h5);
    tick(); bus.cmd_valid = 0;
    chk("wr2_c1_both", {bus.awvalid, bus.wvalid}, 2'b11);
    tick();
    chk("wr2_c2_bready", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("wr2_rsp_stall", {bus.rsp_valid, bus.cmd_ready, bus.rsp_write, bus.rsp_resp,
          bus.rsp_rdata}, {1'b1, 1'b0, 1'b1, 2'd3, 32'h0});
      tick();
    end
    // Command offered in the draining RSP cycle is taken one cycle later
    rd_value = 32'h0BADF00D; rd_resp = 2'd1;
    bus.rsp_ready = 1;
    drive_cmd(1'b0, 32'h00000100, 32'h0, 4'h0);
    tick();
    chk("rsp_cmd_wait", {bus.rsp_valid, bus.cmd_ready, bus.arvalid}, 3'b010);
    tick(); bus.cmd_valid = 0;
    chk("rsp_cmd_taken", {bus.arvalid, bus.ar_addr}, {1'b1, 32'h00000100});
    tick(); tick();
    chk("rd2_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata}, {1'b1, 2'd1, 32'h0BADF00D});
    tick();

    // Reset while the address phase is pending
    ar_delay = 1000;
    drive_cmd(1'b0, 32'h00000200, 32'h0, 4'h0);
    tick(); bus.cmd_valid = 0;
    chk("mid_rst_arvalid", bus.arvalid, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_values", {bus.arvalid, bus.rready, bus.rsp_valid, bus.cmd_ready, bus.ar_addr},
        {4'b0001, 32'h0});
    rst = 1'b0; ar_delay = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_no_rsp", {bus.rsp_valid, bus.arvalid}, 2'b00);
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Address never accepted: watchdog closes the transaction
    ar_delay = 1000; exp_timeout = 1'b1;
    drive_cmd(1'b0, 32'h00000300, 32'h0, 4'h0);
    tick(); bus.cmd_valid = 0;
    for (int k = 1; k <= 16; k++) begin
      chk("to_arvalid_high", bus.arvalid, 1);
      tick();
    end
    chk("to_rsp", {bus.arvalid, bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata},
        {1'b0, 1'b1, 2'd2, 32'h0});
    tick();
    exp_timeout = 1'b0; ar_delay = 0;
    chk("to_back_idle", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
